draw_scheduler: RTL and testbench

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

---
 rtl/draw_scheduler_pkg.sv | 47 ++++
 rtl/draw_scheduler_if.sv | 35 +++
 rtl/draw_watchdog.sv | 40 ++++
 rtl/draw_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_draw_scheduler.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// draw_scheduler_pkg
// Shared definitions for the frame draw scheduler: bus widths, object codes,
// screen geometry and the scheduler state encoding.
//   OBJ_W / X_W / Y_W : widths of the object code and coordinate buses
//   objCode_t         : object codes (0 = nothing requested)
//   ST_*              : scheduler state encoding
//   slotToObject()    : maps an object slot index to its object code
// -----------------------------------------------------------------------------
package draw_scheduler_pkg;

   localparam int OBJ_W = 8;
   localparam int X_W   = 8;
   localparam int Y_W   = 7;

   localparam int X_SCREEN_PIXELS = 160;
   localparam int Y_SCREEN_PIXELS = 120;

   typedef enum logic [OBJ_W-1:0] {
      OBJ_NONE  = 8'd0,
      ROCKET    = 8'd1,
      ASTEROID1 = 8'd2,
      ASTEROID2 = 8'd3,
      ASTEROID3 = 8'd4,
      ASTEROID4 = 8'd5,
      ASTEROID5 = 8'd6,
      ASTEROID6 = 8'd7,
      ASTEROID7 = 8'd8,
      ASTEROID8 = 8'd9
   } objCode_t;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ST_SNAP    = 3'd1;
   localparam logic [STATE_W-1:0] ST_BG_REQ  = 3'd2;
   localparam logic [STATE_W-1:0] ST_SEL     = 3'd3;
   localparam logic [STATE_W-1:0] ST_OBJ_REQ = 3'd4;
   localparam logic [STATE_W-1:0] ST_GAP     = 3'd5;
   localparam logic [STATE_W-1:0] ST_DONE    = 3'd6;

   // Slot 0 is the rocket (code 1); slot i draws code i+1.
   function automatic logic [OBJ_W-1:0] slotToObject(input int unsigned slot);
      return OBJ_W'(slot + 1);
   endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// -----------------------------------------------------------------------------
// draw_scheduler_if
// Request/done bus between the draw scheduler and the sprite drawer /
// background painter.
//   oPlot       : level request, high while a draw is requested
//   oBackground : high while the background pass is requested
//   oObject     : object code being requested, 0 when none
//   oXCoord     : top-left X of the requested object
//   oYCoord     : top-left Y of the requested object
//   iDone       : sprite drawer finished the current object
//   iBgDone     : background painter finished
// Modports: master = scheduler side, slave = drawer side.
// -----------------------------------------------------------------------------
interface draw_scheduler_if;
   import draw_scheduler_pkg::*;

   logic             oPlot;
   logic             oBackground;
   logic [OBJ_W-1:0] oObject;
   logic [X_W-1:0]   oXCoord;
   logic [Y_W-1:0]   oYCoord;
   logic             iDone;
   logic             iBgDone;

   modport master (
      output oPlot, oBackground, oObject, oXCoord, oYCoord,
      input  iDone, iBgDone
   );

   modport slave (
      input  oPlot, oBackground, oObject, oXCoord, oYCoord,
      output iDone, iBgDone
   );

endinterface

// File: rtl/draw_watchdog.sv
// -----------------------------------------------------------------------------
// draw_watchdog
// Bounds the time the scheduler waits for a done response.
//   Clock    : system clock
//   Reset    : asynchronous active-low reset
//   iLoad    : clear the count (asserted on the edge entering a wait state)
//   iEnable  : count while waiting
//   oExpired : high in the wait cycle where the count has reached
//              TIMEOUT_CYCLES-1, i.e. the TIMEOUT_CYCLES-th waiting cycle
// -----------------------------------------------------------------------------
module draw_watchdog #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic Clock,
   input  logic Reset,
   input  logic iLoad,
   input  logic iEnable,
   output logic oExpired
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   assign oExpired = iEnable && (count == LAST_COUNT);

   // Count saturates at LAST_COUNT; the scheduler leaves the wait state on
   // expiry, so the held value is never observed twice.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         count <= '0;
      end else if (iLoad) begin
         count <= '0;
      end else if (iEnable && !oExpired) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/draw_scheduler.sv
// -----------------------------------------------------------------------------
// draw_scheduler
// Sequences one video frame: a background pass followed by every active
// object slot in index order, each handed to the drawer as a level request
// and released by its done response (or a watchdog timeout).
//   Clock       : system clock, all state changes on the rising edge
//   Reset       : asynchronous active-low reset
//   iFrameTick  : one-cycle pulse requesting a new frame
//   iActive     : per-slot enable, bit 0 = rocket
//   iPosX       : packed X per slot, slot i at [8i+7:8i]
//   iPosY       : packed Y per slot, slot i at [7i+6:7i]
//   drawBus     : request/done bus to the drawer (master side)
//   oBusy       : high from the cycle after an accepted tick until DONE
//   oFrameDone  : one-cycle pulse at frame completion
//   oOverrun    : one-cycle pulse after a tick that arrived while busy
//   oError      : sticky, set by any done timeout
// -----------------------------------------------------------------------------
module draw_scheduler
   import draw_scheduler_pkg::*;
#(
   parameter int NUM_OBJECTS    = 9,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic                       iFrameTick,
   input  logic [NUM_OBJECTS-1:0]     iActive,
   input  logic [X_W*NUM_OBJECTS-1:0] iPosX,
   input  logic [Y_W*NUM_OBJECTS-1:0] iPosY,
   draw_scheduler_if.master           drawBus,
   output logic                       oBusy,
   output logic                       oFrameDone,
   output logic                       oOverrun,
   output logic                       oError
);

   // Index must be able to hold NUM_OBJECTS: after the last slot is drawn
   // the index moves one past it and SEL then finishes the frame.
   localparam int IDX_W = (NUM_OBJECTS > 1) ? $clog2(NUM_OBJECTS + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_OBJECTS - 1);

   logic [STATE_W-1:0]           state;
   logic [STATE_W-1:0]           nextState;
   logic [IDX_W-1:0]             slotIdx;

   logic [NUM_OBJECTS-1:0]       snapActive;
   logic [X_W*NUM_OBJECTS-1:0]   snapPosX;
   logic [Y_W*NUM_OBJECTS-1:0]   snapPosY;

   logic                         curActive;
   logic [X_W-1:0]               curX;
   logic [Y_W-1:0]               curY;

   logic                         waitBg;
   logic                         waitObj;
   logic                         bgExit;
   logic                         objExit;
   logic                         lastScan;
   logic                         idxStep;
   logic                         errSet;

   logic                         wdLoad;
   logic                         wdEnable;
   logic                         wdExpired;

   logic                         overrunReg;
   logic                         errorReg;

   // Current-slot view of the snapshot. An index past the last slot reads
   // as inactive, which lets SEL fall through to DONE.
   always_comb begin
      curActive = 1'b0;
      curX      = '0;
      curY      = '0;
      for (int i = 0; i < NUM_OBJECTS; i++) begin
         if (slotIdx == IDX_W'(i)) begin
            curActive = snapActive[i];
            curX      = snapPosX[X_W*i +: X_W];
            curY      = snapPosY[Y_W*i +: Y_W];
         end
      end
   end

   assign waitBg   = (state == ST_BG_REQ);
   assign waitObj  = (state == ST_OBJ_REQ);
   // Done responses only count in their own wait state; anything else is
   // ignored by construction.
   assign bgExit   = waitBg  && (drawBus.iBgDone || wdExpired);
   assign objExit  = waitObj && (drawBus.iDone   || wdExpired);
   assign lastScan = (slotIdx >= LAST_SLOT);

   // A done arriving in the expiry cycle still counts as a clean finish.
   assign errSet   = wdExpired &&
                     ((waitBg && !drawBus.iBgDone) || (waitObj && !drawBus.iDone));

   assign idxStep  = ((state == ST_SEL) && !curActive && !lastScan) || objExit;

   // Watchdog is cleared on the edge that enters either wait state.
   assign wdLoad   = (state == ST_SNAP) || ((state == ST_SEL) && curActive);
   assign wdEnable = waitBg || waitObj;

   draw_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) uWatchdog (
      .Clock    (Clock),
      .Reset    (Reset),
      .iLoad    (wdLoad),
      .iEnable  (wdEnable),
      .oExpired (wdExpired)
   );

   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE:    if (iFrameTick) nextState = ST_SNAP;
         ST_SNAP:    nextState = ST_BG_REQ;
         ST_BG_REQ:  if (bgExit) nextState = ST_GAP;
         ST_SEL: begin
            if (curActive)     nextState = ST_OBJ_REQ;
            else if (lastScan) nextState = ST_DONE;
         end
         ST_OBJ_REQ: if (objExit) nextState = ST_GAP;
         ST_GAP:     nextState = ST_SEL;
         ST_DONE:    nextState = ST_IDLE;
         default:    nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Frame snapshot: captured once so the caller may update object
   // positions for the next frame while this one is being drawn.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         snapActive <= '0;
         snapPosX   <= '0;
         snapPosY   <= '0;
      end else if (state == ST_SNAP) begin
         snapActive <= iActive;
         snapPosX   <= iPosX;
         snapPosY   <= iPosY;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         slotIdx <= '0;
      end else if (state == ST_SNAP) begin
         slotIdx <= '0;
      end else if (idxStep) begin
         slotIdx <= slotIdx + IDX_W'(1);
      end
   end

   // Ticks outside IDLE are dropped; the overrun pulse is the only trace.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         overrunReg <= 1'b0;
         errorReg   <= 1'b0;
      end else begin
         overrunReg <= iFrameTick && (state != ST_IDLE);
         if (errSet) begin
            errorReg <= 1'b1;
         end
      end
   end

   // Outputs decode directly from registered state, so an asynchronous
   // reset clears them in the same cycle.
   assign drawBus.oPlot       = waitBg || waitObj;
   assign drawBus.oBackground = waitBg;
   assign drawBus.oObject     = waitObj ? slotToObject(int'(unsigned'(slotIdx))) : '0;
   assign drawBus.oXCoord     = waitObj ? curX : '0;
   assign drawBus.oYCoord     = waitObj ? curY : '0;

   assign oBusy      = (state != ST_IDLE) && (state != ST_DONE);
   assign oFrameDone = (state == ST_DONE);
   assign oOverrun   = overrunReg;
   assign oError     = errorReg;

endmodule

// File: tb/tb_draw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_draw_scheduler
// Self-checking bench for draw_scheduler. A frame model derives, from the
// active mask, positions and per-request response delays, the list of draw
// requests the scheduler must issue (kind, code, coordinates, length and the
// number of idle cycles before each), plus the expected error flag. The bench
// plays the drawer, records what the scheduler actually requests and compares.
// -----------------------------------------------------------------------------
module tb_draw_scheduler;

   localparam int NUM          = 9;
   localparam int TMO          = 16;
   localparam int FRAME_BUDGET = 1000;

   typedef struct {
      logic       bg;
      logic [7:0] code;
      logic [7:0] x;
      logic [6:0] y;
      int         len;
      int         gap;
      int         dly;
   } seg_t;

   logic             Clock = 1'b0;
   logic             Reset = 1'b0;
   logic             iFrameTick = 1'b0;
   logic [NUM-1:0]   iActive = '0;
   logic [8*NUM-1:0] iPosX = '0;
   logic [7*NUM-1:0] iPosY = '0;
   logic             oBusy;
   logic             oFrameDone;
   logic             oOverrun;
   logic             oError;

   draw_scheduler_if bus ();

   draw_scheduler #(
      .NUM_OBJECTS    (NUM),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .iFrameTick (iFrameTick),
      .iActive    (iActive),
      .iPosX      (iPosX),
      .iPosY      (iPosY),
      .drawBus    (bus),
      .oBusy      (oBusy),
      .oFrameDone (oFrameDone),
      .oOverrun   (oOverrun),
      .oError     (oError)
   );

   always #5 Clock = ~Clock;

   int assertCount = 0;
   int failCount   = 0;

   // Frame configuration consumed by runFrame
   logic [NUM-1:0] frmActive;
   logic [7:0]     frmX [NUM];
   logic [6:0]     frmY [NUM];
   int             bgDelay;
   int             objDelay [NUM];
   int             extraTickAt;
   bit             noise;
   bit             scramble;
   bit             poke99;
   logic           errSticky = 1'b0;
   int             lastDoneCyc;

   task automatic checkVal(input string tag, input logic [31:0] actual,
                           input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic clearCfg();
      frmActive   = '0;
      bgDelay     = 0;
      extraTickAt = -1;
      noise       = 0;
      scramble    = 0;
      poke99      = 0;
      for (int i = 0; i < NUM; i++) begin
         frmX[i]     = 8'd0;
         frmY[i]     = 7'd0;
         objDelay[i] = 0;
      end
   endtask

   function automatic int reqLen(input int d);
      return (d + 1 < TMO) ? d + 1 : TMO;
   endfunction

   task automatic checkOutputsZero(input string name);
      checkVal({name, " plot"},  32'(bus.oPlot),       0);
      checkVal({name, " bg"},    32'(bus.oBackground), 0);
      checkVal({name, " obj"},   32'(bus.oObject),     0);
      checkVal({name, " x"},     32'(bus.oXCoord),     0);
      checkVal({name, " y"},     32'(bus.oYCoord),     0);
      checkVal({name, " busy"},  32'(oBusy),           0);
      checkVal({name, " fdone"}, 32'(oFrameDone),      0);
      checkVal({name, " ovr"},   32'(oOverrun),        0);
      checkVal({name, " err"},   32'(oError),          0);
   endtask

   task automatic runFrame(input string name);
      seg_t expQ[$];
      seg_t obsQ[$];
      seg_t cur;
      seg_t s;
      int   nextSlot, cyc, lowRun, doneCnt, ovrCnt, busyBad, stableBad, tailBad, d;
      int   expOvr;
      logic expErr, busyAtDone, inSeg, finished;

      // Model: background first, then each active slot in index order.
      // Idle cycles before an object = one gap cycle plus one select cycle
      // per slot scanned since the previous request.
      expErr  = errSticky;
      s.bg    = 1'b1;
      s.code  = 8'd0;
      s.x     = 8'd0;
      s.y     = 7'd0;
      s.dly   = bgDelay;
      s.len   = reqLen(bgDelay);
      s.gap   = 1;
      if (bgDelay >= TMO) expErr = 1'b1;
      expQ.push_back(s);
      nextSlot = 0;
      for (int i = 0; i < NUM; i++) begin
         if (frmActive[i]) begin
            s.bg   = 1'b0;
            s.code = 8'(i + 1);
            s.x    = frmX[i];
            s.y    = frmY[i];
            s.dly  = objDelay[i];
            s.len  = reqLen(objDelay[i]);
            s.gap  = 1 + (i - nextSlot + 1);
            nextSlot = i + 1;
            if (objDelay[i] >= TMO) expErr = 1'b1;
            expQ.push_back(s);
         end
      end
      expOvr = (extraTickAt >= 0) ? 1 : 0;

      @(negedge Clock);
      iActive = frmActive;
      for (int i = 0; i < NUM; i++) begin
         iPosX[8*i +: 8] = frmX[i];
         iPosY[7*i +: 7] = frmY[i];
      end
      iFrameTick = 1'b1;
      @(negedge Clock);
      iFrameTick = 1'b0;

      cyc = 0; lowRun = 0; doneCnt = 0; ovrCnt = 0; busyBad = 0;
      stableBad = 0; tailBad = 0; busyAtDone = 1'b1; inSeg = 1'b0; finished = 1'b0;
      cur = s;
      while (!finished && cyc < FRAME_BUDGET) begin
         if (bus.oPlot) begin
            if (!inSeg) begin
               inSeg    = 1'b1;
               cur.bg   = bus.oBackground;
               cur.code = bus.oObject;
               cur.x    = bus.oXCoord;
               cur.y    = bus.oYCoord;
               cur.len  = 0;
               cur.gap  = lowRun;
               cur.dly  = 0;
            end else if (bus.oBackground !== cur.bg || bus.oObject !== cur.code ||
                         bus.oXCoord !== cur.x || bus.oYCoord !== cur.y) begin
               stableBad++;
            end
            cur.len++;
         end else begin
            if (inSeg) begin
               obsQ.push_back(cur);
               inSeg  = 1'b0;
               lowRun = 0;
            end
            lowRun++;
         end
         if (oOverrun) ovrCnt++;
         if (oFrameDone) begin
            doneCnt++;
            busyAtDone  = oBusy;
            lastDoneCyc = cyc;
            finished    = 1'b1;
         end else if (!oBusy) begin
            busyBad++;
         end

         // Drawer responses for the coming edge
         bus.iDone   = 1'b0;
         bus.iBgDone = 1'b0;
         if (inSeg) begin
            d = (obsQ.size() < expQ.size()) ? expQ[obsQ.size()].dly : 0;
            if (cur.len - 1 == d) begin
               if (cur.bg) bus.iBgDone = 1'b1;
               else        bus.iDone   = 1'b1;
            end else if (noise && $urandom_range(0, 3) == 0) begin
               if (cur.bg) bus.iDone   = 1'b1;
               else        bus.iBgDone = 1'b1;
            end
         end else if (noise && $urandom_range(0, 3) == 0) begin
            bus.iDone   = 1'b1;
            bus.iBgDone = 1'b1;
         end
         iFrameTick = (cyc == extraTickAt);
         if (poke99 && inSeg && !cur.bg) iPosX[7:0] = 8'd99;
         if (scramble && (inSeg || obsQ.size() > 0)) begin
            iActive = NUM'($urandom);
            for (int i = 0; i < NUM; i++) begin
               iPosX[8*i +: 8] = 8'($urandom);
               iPosY[7*i +: 7] = 7'($urandom);
            end
         end
         if (!finished) begin
            @(negedge Clock);
            cyc++;
         end
      end
      if (inSeg) obsQ.push_back(cur);

      iFrameTick  = 1'b0;
      bus.iDone   = 1'b0;
      bus.iBgDone = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge Clock);
         if (bus.oPlot || oBusy || oFrameDone) tailBad++;
         if (oOverrun) ovrCnt++;
      end

      checkVal({name, " finished"}, 32'(finished), 1);
      checkVal({name, " nreq"}, 32'(obsQ.size()), 32'(expQ.size()));
      for (int i = 0; i < expQ.size(); i++) begin
         if (i < obsQ.size()) begin
            checkVal($sformatf("%s req%0d bg", name, i),   32'(obsQ[i].bg),   32'(expQ[i].bg));
            checkVal($sformatf("%s req%0d code", name, i), 32'(obsQ[i].code), 32'(expQ[i].code));
            if (!expQ[i].bg) begin
               checkVal($sformatf("%s req%0d x", name, i), 32'(obsQ[i].x), 32'(expQ[i].x));
               checkVal($sformatf("%s req%0d y", name, i), 32'(obsQ[i].y), 32'(expQ[i].y));
            end
            checkVal($sformatf("%s req%0d len", name, i), 32'(obsQ[i].len), 32'(expQ[i].len));
            checkVal($sformatf("%s req%0d gap", name, i), 32'(obsQ[i].gap), 32'(expQ[i].gap));
         end
      end
      checkVal({name, " fdone count"}, 32'(doneCnt), 1);
      checkVal({name, " busy at done"}, 32'(busyAtDone), 0);
      checkVal({name, " busy drops"}, 32'(busyBad), 0);
      checkVal({name, " req stable"}, 32'(stableBad), 0);
      checkVal({name, " idle after"}, 32'(tailBad), 0);
      checkVal({name, " overrun"}, 32'(ovrCnt), 32'(expOvr));
      checkVal({name, " error"}, 32'(oError), 32'(expErr));
      errSticky = expErr;
   endtask

   initial begin
      int  waitCyc;
      bit  found;

      bus.iDone   = 1'b0;
      bus.iBgDone = 1'b0;
      clearCfg();

      // Reset state
      repeat (3) @(negedge Clock);
      checkOutputsZero("reset");
      Reset = 1'b1;

      // Two adjacent objects, position change during drawing
      clearCfg();
      frmActive = 9'h003;
      frmX[0] = 8'd20; frmY[0] = 7'd30;
      frmX[1] = 8'd50; frmY[1] = 7'd10;
      bgDelay = 5; objDelay[0] = 3; objDelay[1] = 3;
      poke99 = 1;
      runFrame("two_obj");

      // Tick while busy
      poke99 = 0;
      extraTickAt = 3;
      runFrame("overrun");

      // Object never completes
      clearCfg();
      frmActive = 9'h001;
      frmX[0] = 8'd7; frmY[0] = 7'd100;
      objDelay[0] = 1000;
      runFrame("timeout");

      // Empty frame latency
      clearCfg();
      runFrame("empty");
      checkVal("empty tick to done", 32'(lastDoneCyc + 1), 13);

      // Reset while object 2 is requested
      clearCfg();
      iActive = 9'h003;
      iPosX   = '0;
      iPosY   = '0;
      iPosX[7:0] = 8'd20; iPosX[15:8] = 8'd50;
      @(negedge Clock);
      iFrameTick = 1'b1;
      @(negedge Clock);
      iFrameTick = 1'b0;
      found   = 0;
      waitCyc = 0;
      while (!found && waitCyc < 200) begin
         if (bus.oPlot && bus.oObject == 8'd2) begin
            found = 1;
         end else begin
            bus.iBgDone = bus.oPlot && bus.oBackground;
            bus.iDone   = bus.oPlot && (bus.oObject == 8'd1);
            @(negedge Clock);
            waitCyc++;
         end
      end
      checkVal("midreset reached obj2", 32'(found), 1);
      bus.iDone   = 1'b0;
      bus.iBgDone = 1'b0;
      Reset = 1'b0;
      #1;
      checkOutputsZero("midreset");
      @(negedge Clock);
      Reset = 1'b1;
      errSticky = 1'b0;

      clearCfg();
      frmActive = 9'h103;
      frmX[0] = 8'd1;   frmY[0] = 7'd2;
      frmX[1] = 8'd200; frmY[1] = 7'd127;
      frmX[8] = 8'd255; frmY[8] = 7'd0;
      bgDelay = 2; objDelay[0] = 0; objDelay[1] = 15; objDelay[8] = 4;
      runFrame("after_reset");

      // Randomized frames
      for (int f = 0; f < 25; f++) begin
         clearCfg();
         frmActive = NUM'($urandom);
         for (int i = 0; i < NUM; i++) begin
            frmX[i]     = 8'($urandom);
            frmY[i]     = 7'($urandom);
            objDelay[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 40))
                                                       : int'($urandom_range(0, 15));
         end
         bgDelay     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 40))
                                                    : int'($urandom_range(0, 15));
         extraTickAt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
         noise       = 1;
         scramble    = 1;
         if ($urandom_range(0, 4) == 0) begin
            @(negedge Clock);
            Reset = 1'b0;
            @(negedge Clock);
            checkVal($sformatf("rnd%0d reset err", f), 32'(oError), 0);
            Reset = 1'b1;
            errSticky = 1'b0;
         end
         runFrame($sformatf("rnd%0d", f));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
